// File: rtl/binary_op_arbiter.sv
// -----------------------------------------------------------------------------
// binary_op_arbiter
//
// Shares one MOV binary-operation datapath (pass / invert / bit-reverse)
// between NUM_REQ requesters using round-robin arbitration. A single
// registered result slot allows one accepted operation per cycle.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   reset         asynchronous active-high reset
//   in_valid      per-requester request valid            [NUM_REQ]
//   in_data       per-requester 32-bit operand           [32*NUM_REQ]
//   in_op         per-requester op (00 pass, 01 invert, 10 reverse, 11 illegal)
//   in_ready      one-hot-or-zero grant                  [NUM_REQ]
//   out_valid     result slot holds a valid result
//   out_data      32-bit result (0 for illegal op)
//   out_id        index of the requester owning out_data (zero-extended)
//   out_op_error  result came from op 11
//   out_ready     consumer accepts the result
// -----------------------------------------------------------------------------
module binary_op_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    in_valid,
   input  logic [32*NUM_REQ-1:0] in_data,
   input  logic [2*NUM_REQ-1:0]  in_op,
   output logic [NUM_REQ-1:0]    in_ready,
   output logic                  out_valid,
   output logic [31:0]           out_data,
   output logic [2:0]            out_id,
   output logic                  out_op_error,
   input  logic                  out_ready
);

   // Requester inputs are padded to 8 entries so a 3-bit index can select
   // them for any legal NUM_REQ; absent requesters read as idle zeros.
   localparam int MAX_REQ = 8;

   logic [MAX_REQ-1:0] valid_pad;
   logic [31:0]        data_pad [MAX_REQ];
   logic [1:0]         op_pad   [MAX_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < MAX_REQ; gi++) begin : g_pad
         if (gi < NUM_REQ) begin : g_real
            assign valid_pad[gi] = in_valid[gi];
            assign data_pad[gi]  = in_data[32*gi +: 32];
            assign op_pad[gi]    = in_op[2*gi +: 2];
         end else begin : g_absent
            assign valid_pad[gi] = 1'b0;
            assign data_pad[gi]  = 32'h0;
            assign op_pad[gi]    = 2'b00;
         end
      end
   endgenerate

   logic        out_valid_reg;
   logic [31:0] out_data_reg;
   logic [2:0]  out_id_reg;
   logic        out_op_error_reg;
   logic [2:0]  last_grant_reg;

   logic        slot_free;
   logic        found;
   logic [2:0]  winner;
   logic        accept;

   assign slot_free = !out_valid_reg || out_ready;

   // Round-robin search starting just after the last granted index.
   always_comb begin
      logic [3:0] cand;
      found  = 1'b0;
      winner = 3'd0;
      cand   = 4'd0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_grant_reg} + 4'(k);
         if (cand >= 4'(NUM_REQ)) begin
            cand = cand - 4'(NUM_REQ);
         end
         if (!found && valid_pad[cand[2:0]]) begin
            found  = 1'b1;
            winner = cand[2:0];
         end
      end
   end

   // Gating with reset keeps every grant low while reset is asserted.
   assign accept = found && slot_free && !reset;

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign in_ready[gi] = accept && (winner == 3'(gi));
      end
   endgenerate

   // Shared operation datapath on the winning operand.
   logic [31:0] sel_data;
   logic [1:0]  sel_op;
   logic [31:0] rev_data;
   logic [31:0] result_next;
   logic        op_error_next;

   assign sel_data = data_pad[winner];
   assign sel_op   = op_pad[winner];

   generate
      for (gi = 0; gi < 32; gi++) begin : g_rev
         assign rev_data[gi] = sel_data[31-gi];
      end
   endgenerate

   always_comb begin
      result_next   = 32'h0;
      op_error_next = 1'b0;
      case (sel_op)
         2'b00:   result_next = sel_data;
         2'b01:   result_next = ~sel_data;
         2'b10:   result_next = rev_data;
         default: begin
            result_next   = 32'h0;
            op_error_next = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_reg    <= 1'b0;
         out_data_reg     <= 32'h0;
         out_id_reg       <= 3'd0;
         out_op_error_reg <= 1'b0;
         last_grant_reg   <= 3'(NUM_REQ-1);
      end else if (accept) begin
         // Also covers simultaneous drain+accept: new result replaces old.
         out_valid_reg    <= 1'b1;
         out_data_reg     <= result_next;
         out_id_reg       <= winner;
         out_op_error_reg <= op_error_next;
         last_grant_reg   <= winner;
      end else if (out_ready) begin
         // Drain without refill; payload holds its last value.
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid    = out_valid_reg;
   assign out_data     = out_data_reg;
   assign out_id       = out_id_reg;
   assign out_op_error = out_op_error_reg;

endmodule
